// File: rtl/steer_en_ctrl.sv
// steer_en_ctrl: rider-presence and steering-enable controller.
// Stage 1 registers the load sum/difference comparisons and stage 2 runs
// the state machine on them, so an input change reaches the outputs in 2 clk.
// Optional build macro RIDER_OFF_DBNC_EN: requires sum_lt_min on 4
// consecutive clk before any exit to OFF.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_OFF   | no rider; timer held at 0; rider_off=1
//   ST_WAIT  | rider present; timer counts while the load stays balanced
//   ST_STEER | balanced long enough; en_steer=1
module steer_en_ctrl #(
   parameter bit          FAST_SIM     = 1'b0,
   parameter logic [11:0] MIN_RIDER_WT = 12'h200,
   parameter logic [11:0] WT_HYST      = 12'h40
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] lft_ld,
   input  logic [11:0] rght_ld,
   output logic        en_steer,
   output logic        rider_off,
   output logic        tmr_full
);

   localparam int TMR_BITS = FAST_SIM ? 15 : 26;
   localparam logic [12:0] THR_HI = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
   localparam logic [12:0] THR_LO = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};
   localparam logic [TMR_BITS-1:0] TMR_ONE = {{(TMR_BITS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_STEER = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [TMR_BITS-1:0] tmr_q, tmr_d;

   logic [12:0] sum;
   logic [11:0] adiff;
   logic        sum_gt_min_d, sum_gt_min_q;
   logic        sum_lt_min_d, sum_lt_min_q;
   logic        diff_gt_1_4_d, diff_gt_1_4_q;
   logic        diff_gt_15_16_d, diff_gt_15_16_q;
   logic        exit_off;

   // Stage-1 comparisons on the raw load-cell readings
   always_comb begin
      sum             = {1'b0, lft_ld} + {1'b0, rght_ld};
      adiff           = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
      sum_gt_min_d    = (sum > THR_HI);
      sum_lt_min_d    = (sum < THR_LO);
      diff_gt_1_4_d   = ({1'b0, adiff} > (sum >> 2));
      diff_gt_15_16_d = ({1'b0, adiff} > (sum - (sum >> 4)));
   end

   // Stage-1 condition registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_gt_min_q    <= 1'b0;
         sum_lt_min_q    <= 1'b0;
         diff_gt_1_4_q   <= 1'b0;
         diff_gt_15_16_q <= 1'b0;
      end else begin
         sum_gt_min_q    <= sum_gt_min_d;
         sum_lt_min_q    <= sum_lt_min_d;
         diff_gt_1_4_q   <= diff_gt_1_4_d;
         diff_gt_15_16_q <= diff_gt_15_16_d;
      end
   end

`ifdef RIDER_OFF_DBNC_EN
   logic [1:0] dbnc_q, dbnc_d;

   // Count consecutive low-load cycles, saturating at 3
   always_comb begin
      dbnc_d = 2'd0;
      if (sum_lt_min_q) begin
         dbnc_d = (dbnc_q == 2'd3) ? 2'd3 : (dbnc_q + 2'd1);
      end
   end

   // Debounce counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbnc_q <= 2'd0;
      end else begin
         dbnc_q <= dbnc_d;
      end
   end

   // Fourth consecutive low-load cycle is the one that exits
   assign exit_off = sum_lt_min_q && (dbnc_q == 2'd3);
`else
   assign exit_off = sum_lt_min_q;
`endif

   // Next-state and timer logic; every entry to WAIT or OFF zeroes the timer
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      case (state_q)
         ST_OFF: begin
            tmr_d = '0;
            if (sum_gt_min_q) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (exit_off) begin
               state_d = ST_OFF;
               tmr_d   = '0;
            end else if (diff_gt_1_4_q) begin
               tmr_d = '0;
            end else if (tmr_full) begin
               state_d = ST_STEER;
            end else begin
               tmr_d = tmr_q + TMR_ONE;
            end
         end
         ST_STEER: begin
            if (exit_off) begin
               state_d = ST_OFF;
               tmr_d   = '0;
            end else if (diff_gt_15_16_q) begin
               state_d = ST_WAIT;
               tmr_d   = '0;
            end
         end
         default: begin
            state_d = ST_OFF;
            tmr_d   = '0;
         end
      endcase
   end

   // State and timer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_OFF;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
      end
   end

   assign tmr_full  = &tmr_q;
   assign en_steer  = (state_q == ST_STEER);
   assign rider_off = (state_q == ST_OFF);

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Testbench for steer_en_ctrl (FAST_SIM=1). Directed scenarios plus a
// randomized phase, compared every cycle against a behavioural model.
module tb_steer_en_ctrl;

   localparam int TMR_MAX = 32767;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] lft_ld = '0;
   logic [11:0] rght_ld = '0;
   logic        en_steer, rider_off, tmr_full;

   int n_checks = 0;
   int n_errors = 0;

   steer_en_ctrl #(.FAST_SIM(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .lft_ld    (lft_ld),
      .rght_ld   (rght_ld),
      .en_steer  (en_steer),
      .rider_off (rider_off),
      .tmr_full  (tmr_full)
   );

   always #5 clk = ~clk;

   // Reference model: 0=off 1=waiting 2=steering; loads seen one clk late
   int          m_st  = 0;
   int          m_tmr = 0;
   int          m_dbc = 0;
   bit          m_vld = 1'b0;
   logic [11:0] p_l = '0;
   logic [11:0] p_r = '0;

   always @(posedge clk or negedge rst_n) begin : model
      int s, d;
      bit gt, lt, d14, d1516, ex;
      if (!rst_n) begin
         m_st = 0; m_tmr = 0; m_dbc = 0; m_vld = 1'b0;
      end else begin
         gt = 0; lt = 0; d14 = 0; d1516 = 0;
         if (m_vld) begin
            s     = int'(p_l) + int'(p_r);
            d     = (p_l > p_r) ? int'(p_l) - int'(p_r) : int'(p_r) - int'(p_l);
            gt    = (s > 'h240);
            lt    = (s < 'h1C0);
            d14   = (d > s / 4);
            d1516 = (d > s - s / 16);
         end
`ifdef RIDER_OFF_DBNC_EN
         m_dbc = lt ? m_dbc + 1 : 0;
         ex    = lt && (m_dbc >= 4);
`else
         ex    = lt;
`endif
         case (m_st)
            0: if (gt) begin m_st = 1; m_tmr = 0; end
            1: begin
               if (ex) begin m_st = 0; m_tmr = 0; end
               else if (d14) m_tmr = 0;
               else if (m_tmr == TMR_MAX) m_st = 2;
               else m_tmr = m_tmr + 1;
            end
            default: begin
               if (ex) begin m_st = 0; m_tmr = 0; end
               else if (d1516) begin m_st = 1; m_tmr = 0; end
            end
         endcase
         p_l   = lft_ld;
         p_r   = rght_ld;
         m_vld = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_en"},   32'(en_steer),  32'(m_st == 2));
      chk({tag, "_off"},  32'(rider_off), 32'(m_st == 0));
      chk({tag, "_full"}, 32'(tmr_full),  32'(m_tmr == TMR_MAX));
   endtask

   task automatic cyc(input int n, input string tag);
      repeat (n) begin
         @(negedge clk);
         chk_model(tag);
      end
   endtask

   initial begin
      // reset with random loads
      lft_ld  = 12'($urandom);
      rght_ld = 12'($urandom);
      #1;
      chk("rst_off",  32'(rider_off), 32'd1);
      chk("rst_en",   32'(en_steer),  32'd0);
      chk("rst_full", 32'(tmr_full),  32'd0);
      cyc(3, "rst_hold");
      lft_ld = '0; rght_ld = '0; rst_n = 1'b1;
      cyc(5, "idle");
      chk("idle_off", 32'(rider_off), 32'd1);

      // rider mounts balanced
      lft_ld = 12'h150; rght_ld = 12'h150;
      cyc(1, "mnt");
      chk("mnt_off1", 32'(rider_off), 32'd1);
      cyc(1, "mnt");
      chk("mnt_off2", 32'(rider_off), 32'd0);
      cyc(1000, "wait1");

      // imbalance clears the timer, restore and count the full interval
      lft_ld = 12'h200; rght_ld = 12'h0A0;
      cyc(50, "imb");
      chk("imb_en", 32'(en_steer), 32'd0);
      lft_ld = 12'h150; rght_ld = 12'h150;
      cyc(32768, "cnt1");
      chk("cnt1_full", 32'(tmr_full), 32'd1);
      chk("cnt1_en0",  32'(en_steer), 32'd0);
      cyc(1, "cnt1");
      chk("cnt1_en1",  32'(en_steer), 32'd1);

      // steering exit on large imbalance only
      lft_ld = 12'h250; rght_ld = 12'h050;
      cyc(20, "st_ok");
      chk("st_ok_en", 32'(en_steer), 32'd1);
      lft_ld = 12'h290; rght_ld = 12'h010;
      cyc(1, "st_ex");
      chk("st_ex_en1", 32'(en_steer), 32'd1);
      cyc(1, "st_ex");
      chk("st_ex_en0",  32'(en_steer),  32'd0);
      chk("st_ex_off",  32'(rider_off), 32'd0);
      chk("st_ex_tmr",  32'(dut.tmr_q), 32'd0);

      // reset mid-WAIT, then the full count restarts from zero
      lft_ld = 12'h150; rght_ld = 12'h150;
      cyc(5000, "w2");
      rst_n = 1'b0;
      #1;
      chk("mid_rst_off", 32'(rider_off), 32'd1);
      chk("mid_rst_tmr", 32'(dut.tmr_q), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1, "rel");
      chk("rel_off1", 32'(rider_off), 32'd1);
      cyc(1, "rel");
      chk("rel_off0", 32'(rider_off), 32'd0);
      cyc(32767, "cnt2");
      chk("cnt2_full", 32'(tmr_full), 32'd1);
      chk("cnt2_en0",  32'(en_steer), 32'd0);
      cyc(1, "cnt2");
      chk("cnt2_en1",  32'(en_steer), 32'd1);

      // hysteresis band holds STEER
      lft_ld = 12'h100; rght_ld = 12'h100;
      cyc(20, "hyst");
      chk("hyst_en", 32'(en_steer), 32'd1);
`ifdef RIDER_OFF_DBNC_EN
      lft_ld = 12'h0D8; rght_ld = 12'h0D8;
      cyc(1, "glitch");
      lft_ld = 12'h100; rght_ld = 12'h100;
      cyc(10, "glitch");
      chk("glitch_en", 32'(en_steer), 32'd1);
`endif

      // dismount
      lft_ld = 12'h0D8; rght_ld = 12'h0D8;
`ifdef RIDER_OFF_DBNC_EN
      cyc(4, "dis");
`else
      cyc(1, "dis");
`endif
      chk("dis_en1", 32'(en_steer), 32'd1);
      cyc(1, "dis");
      chk("dis_en0", 32'(en_steer),  32'd0);
      chk("dis_off", 32'(rider_off), 32'd1);

      // randomized segments, some near the thresholds, occasional reset
      for (int i = 0; i < 80; i++) begin
         int mode, base, dv;
         mode = $urandom_range(0, 3);
         if (mode == 0) begin
            lft_ld  = 12'($urandom);
            rght_ld = 12'($urandom);
         end else begin
            base    = $urandom_range('hC0, 'h150);
            dv      = $urandom_range(0, (mode == 1) ? 'h10 : 'hC0);
            lft_ld  = 12'(base + dv);
            rght_ld = 12'(base - dv / 2);
         end
         if ($urandom_range(0, 15) == 0) begin
            rst_n = 1'b0;
            #1;
            chk_model("rnd_rst");
            @(negedge clk);
            rst_n = 1'b1;
         end
         cyc($urandom_range(1, 40), "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
